// File: rtl/sram_arbiter.sv
// Shares one single-port sram between an IFU read port and an LSU read/write port.
// A single access is in flight at a time: IDLE accepts, BUSY talks to the sram, RESP returns data.
module sram_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int FIX_PRIO = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_ready,
    output logic          ifu_rvalid,
    output logic [DW-1:0] ifu_rdata,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_ready,
    output logic          lsu_done,
    output logic [DW-1:0] lsu_rdata,
    output logic          err,
    output logic          sram_ren,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    output logic [7:0]    sram_wmask,
    input  logic [DW-1:0] sram_rdata,
    input  logic          sram_valid
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_lsu_q, last_lsu_d;
    logic          owner_lsu_q, owner_lsu_d;
    logic          we_q, we_d;
    logic          wr_issued_q, wr_issued_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    wmask_q, wmask_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          grant_lsu;

    always_comb begin
        state_d     = state_q;
        last_lsu_d  = last_lsu_q;
        owner_lsu_d = owner_lsu_q;
        we_d        = we_q;
        wr_issued_d = wr_issued_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        ifu_ready   = 1'b0;
        lsu_ready   = 1'b0;
        // On a tie, round-robin hands the grant to whoever did not win last time.
        grant_lsu   = lsu_req && (!ifu_req || (FIX_PRIO != 0) || !last_lsu_q);
        case (state_q)
            IDLE: begin
                if (ifu_req || lsu_req) begin
                    ifu_ready   = !grant_lsu;
                    lsu_ready   = grant_lsu;
                    last_lsu_d  = grant_lsu;
                    owner_lsu_d = grant_lsu;
                    we_d        = grant_lsu && lsu_we;
                    addr_d      = grant_lsu ? lsu_addr : ifu_addr;
                    wdata_d     = grant_lsu ? lsu_wdata : '0;
                    wmask_d     = (grant_lsu && lsu_we) ? lsu_wmask : 8'h00;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    wr_issued_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                wr_issued_d = 1'b1;
                if (sram_valid) begin
                    if (!we_q) rdata_d = sram_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_lsu_q  <= 1'b1;
            owner_lsu_q <= 1'b0;
            we_q        <= 1'b0;
            wr_issued_q <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= 8'h00;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_lsu_q  <= last_lsu_d;
            owner_lsu_q <= owner_lsu_d;
            we_q        <= we_d;
            wr_issued_q <= wr_issued_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // A write is strobed once only; reads keep ren up until the sram answers.
    assign sram_ren   = (state_q == BUSY) && !we_q;
    assign sram_wen   = (state_q == BUSY) && we_q && !wr_issued_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_wmask = (state_q == BUSY) ? wmask_q : 8'h00;

    assign ifu_rvalid = (state_q == RESP) && !owner_lsu_q;
    assign lsu_done   = (state_q == RESP) && owner_lsu_q;
    assign ifu_rdata  = rdata_q;
    assign lsu_rdata  = rdata_q;
    assign err        = (state_q == RESP) && err_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin instance (a_*) and a fixed-priority instance (b_*)
// share stimulus; each has a small sram model with 1-cycle read latency and same-cycle write accept.
module tb_sram_arbiter;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0, mem_val = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        stall = 1'b0;

    logic        a_ifu_ready, a_ifu_rvalid, a_lsu_ready, a_lsu_done, a_err, a_ren, a_wen, a_valid;
    logic [31:0] a_ifu_rdata, a_lsu_rdata, a_addr, a_wdata;
    logic [7:0]  a_wmask;
    logic        b_ifu_ready, b_ifu_rvalid, b_lsu_ready, b_lsu_done, b_err, b_ren, b_wen, b_valid;
    logic [31:0] b_ifu_rdata, b_lsu_rdata, b_addr, b_wdata;
    logic [7:0]  b_wmask;
    logic        a_pend = 1'b0, b_pend = 1'b0;

    int cyc = 0, wen_cnt = 0;
    int checks = 0, errors = 0;

    typedef struct {
        logic        lsu;
        logic [31:0] data;
        logic        err;
        int          t;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sram_arbiter #(.AW(32), .DW(32), .FIX_PRIO(0), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(a_ifu_ready),
        .ifu_rvalid(a_ifu_rvalid), .ifu_rdata(a_ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_ready(a_lsu_ready), .lsu_done(a_lsu_done),
        .lsu_rdata(a_lsu_rdata), .err(a_err),
        .sram_ren(a_ren), .sram_wen(a_wen), .sram_addr(a_addr), .sram_wdata(a_wdata),
        .sram_wmask(a_wmask), .sram_rdata(mem_val), .sram_valid(a_valid)
    );

    sram_arbiter #(.AW(32), .DW(32), .FIX_PRIO(1), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(b_ifu_ready),
        .ifu_rvalid(b_ifu_rvalid), .ifu_rdata(b_ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_ready(b_lsu_ready), .lsu_done(b_lsu_done),
        .lsu_rdata(b_lsu_rdata), .err(b_err),
        .sram_ren(b_ren), .sram_wen(b_wen), .sram_addr(b_addr), .sram_wdata(b_wdata),
        .sram_wmask(b_wmask), .sram_rdata(mem_val), .sram_valid(b_valid)
    );

    // sram models: read data one cycle after ren, write accepted with wen
    assign a_valid = (a_pend | a_wen) & !stall;
    assign b_valid = (b_pend | b_wen) & !stall;
    always @(posedge clk) begin
        a_pend  <= a_ren & !a_valid;
        b_pend  <= b_ren & !b_valid;
        cyc     <= cyc + 1;
        if (a_wen) wen_cnt <= wen_cnt + 1;
    end

    // Called at a negedge; returns the cycle of acceptance (-1 if never) and ends at the next negedge.
    task automatic issue_ifu(input logic [31:0] addr, output int t);
        t = -1;
        ifu_addr = addr;
        ifu_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (a_ifu_ready) begin t = cyc; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        ifu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue_lsu(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [7:0] wm, output int t);
        t = -1;
        lsu_we = we; lsu_addr = addr; lsu_wdata = wd; lsu_wmask = wm;
        lsu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (a_lsu_ready) begin t = cyc; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        lsu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_resp(output int tr);
        tr = -1;
        for (int i = 0; i < 40; i++) begin
            if (a_ifu_rvalid || a_lsu_done) begin tr = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ifu_ready, a_ifu_rvalid, a_lsu_ready, a_lsu_done, a_err, a_ren, a_wen} !== 7'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 0000000",
                     {a_ifu_ready, a_ifu_rvalid, a_lsu_ready, a_lsu_done, a_err, a_ren, a_wen});
        end
        checks++;
        if (a_wmask !== 8'h00 || a_ifu_rdata !== 32'h0 || a_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs got wmask=%h rdata=%h addr=%h want 0", a_wmask, a_ifu_rdata, a_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Fresh out of reset last_grant is LSU, so round-robin starts with IFU.
    task automatic test_arb();
        int  ga = 0;
        logic exp_lsu = 1'b0;
        ifu_addr = 32'h8000_0100; lsu_addr = 32'h8000_0200; lsu_we = 1'b0;
        mem_val  = 32'h1111_2222;
        ifu_req = 1'b1; lsu_req = 1'b1;
        for (int i = 0; i < 60 && ga < 4; i++) begin
            #1;
            if (a_ifu_ready || a_lsu_ready) begin
                checks++;
                if ({a_ifu_ready, a_lsu_ready} !== {!exp_lsu, exp_lsu}) begin
                    errors++;
                    $display("FAIL rr_grant%0d got ifu=%b lsu=%b want lsu=%b", ga, a_ifu_ready, a_lsu_ready, exp_lsu);
                end
                checks++;
                if ({b_ifu_ready, b_lsu_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL fix_grant%0d got ifu=%b lsu=%b want lsu only", ga, b_ifu_ready, b_lsu_ready);
                end
                exp_lsu = !exp_lsu;
                ga++;
            end
            if (ga < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_req = 1'b0;
        checks++;
        if (ga != 4) begin errors++; $display("FAIL rr_grant_count got %0d want 4", ga); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_ifu_read();
        int t, tr;
        exp_t e;
        mem_val = 32'hDEAD_BEEF;
        issue_ifu(32'h8000_0000, t);
        sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, t + 3});
        checks++;
        if (a_ren !== 1'b1 || a_wen !== 1'b0 || a_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL ifu_busy got ren=%b wen=%b addr=%h want 1 0 80000000", a_ren, a_wen, a_addr);
        end
        wait_resp(tr);
        e = sb.pop_front();
        checks++;
        if (tr != e.t) begin errors++; $display("FAIL ifu_latency got %0d want %0d", tr, e.t); end
        checks++;
        if ({a_ifu_rvalid, a_lsu_done, a_err, a_ifu_rdata} !== {!e.lsu, e.lsu, e.err, e.data}) begin
            errors++;
            $display("FAIL ifu_resp got v=%b d=%b err=%b data=%h want err=%b data=%h",
                     a_ifu_rvalid, a_lsu_done, a_err, a_ifu_rdata, e.err, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_lsu_write();
        int t, tr, w0;
        exp_t e;
        w0 = wen_cnt;
        issue_lsu(1'b1, 32'h8000_0010, 32'h1234_5678, 8'h0F, t);
        sb.push_back('{1'b1, 32'h0, 1'b0, t + 2});
        checks++;
        if ({a_wen, a_ren, a_addr, a_wdata, a_wmask} !== {2'b10, 32'h8000_0010, 32'h1234_5678, 8'h0F}) begin
            errors++;
            $display("FAIL wr_strobe got wen=%b ren=%b addr=%h wdata=%h wmask=%h want 1 0 80000010 12345678 0f",
                     a_wen, a_ren, a_addr, a_wdata, a_wmask);
        end
        wait_resp(tr);
        e = sb.pop_front();
        checks++;
        if (tr != e.t) begin errors++; $display("FAIL wr_latency got %0d want %0d", tr, e.t); end
        checks++;
        if ({a_lsu_done, a_ifu_rvalid, a_err} !== {e.lsu, !e.lsu, e.err}) begin
            errors++;
            $display("FAIL wr_resp got done=%b rvalid=%b err=%b want 1 0 0", a_lsu_done, a_ifu_rvalid, a_err);
        end
        checks++;
        if (a_wmask !== 8'h00) begin errors++; $display("FAIL wr_mask_idle got %h want 00", a_wmask); end
        repeat (3) @(negedge clk);
        checks++;
        if (wen_cnt - w0 != 1) begin errors++; $display("FAIL wr_wen_cycles got %0d want 1", wen_cnt - w0); end
    endtask

    task automatic test_lsu_read();
        int t, tr;
        exp_t e;
        mem_val = 32'hCAFE_F00D;
        issue_lsu(1'b0, 32'h8000_0020, 32'hFFFF_FFFF, 8'hFF, t);
        sb.push_back('{1'b1, 32'hCAFE_F00D, 1'b0, t + 3});
        checks++;
        if (a_ren !== 1'b1 || a_wen !== 1'b0 || a_wmask !== 8'h00) begin
            errors++;
            $display("FAIL lsu_rd_busy got ren=%b wen=%b wmask=%h want 1 0 00", a_ren, a_wen, a_wmask);
        end
        wait_resp(tr);
        e = sb.pop_front();
        checks++;
        if (tr != e.t) begin errors++; $display("FAIL lsu_rd_latency got %0d want %0d", tr, e.t); end
        checks++;
        if ({a_lsu_done, a_err, a_lsu_rdata} !== {e.lsu, e.err, e.data}) begin
            errors++;
            $display("FAIL lsu_rd_resp got done=%b err=%b data=%h want 1 0 %h", a_lsu_done, a_err, a_lsu_rdata, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int t, tr;
        exp_t e;
        stall   = 1'b1;
        mem_val = 32'h55AA_55AA;
        issue_ifu(32'h8000_0040, t);
        sb.push_back('{1'b0, 32'h0, 1'b1, t + 1 + TO});
        wait_resp(tr);
        e = sb.pop_front();
        checks++;
        if (tr != e.t) begin errors++; $display("FAIL to_latency got %0d want %0d", tr, e.t); end
        checks++;
        if ({a_ifu_rvalid, a_err, a_ifu_rdata} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL to_resp got v=%b err=%b data=%h want 1 1 0", a_ifu_rvalid, a_err, a_ifu_rdata);
        end
        stall = 1'b0;
        repeat (2) @(negedge clk);
        mem_val = 32'h0F0F_A5A5;
        issue_ifu(32'h8000_0044, t);
        sb.push_back('{1'b0, 32'h0F0F_A5A5, 1'b0, t + 3});
        wait_resp(tr);
        e = sb.pop_front();
        checks++;
        if (tr != e.t || {a_err, a_ifu_rdata} !== {e.err, e.data}) begin
            errors++;
            $display("FAIL to_next got t=%0d err=%b data=%h want t=%0d 0 %h", tr, a_err, a_ifu_rdata, e.t, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int t, tr, pulses = 0;
        exp_t e;
        stall = 1'b1;
        issue_ifu(32'h8000_0080, t);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ren, a_wen, a_ifu_rvalid, a_lsu_done, a_err} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset got ren=%b wen=%b rvalid=%b done=%b err=%b want 0",
                     a_ren, a_wen, a_ifu_rvalid, a_lsu_done, a_err);
        end
        rst = 1'b1; stall = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (a_ifu_rvalid || a_lsu_done) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL mid_reset_pulse got %0d want 0", pulses); end
        mem_val = 32'h0BAD_F00D;
        issue_lsu(1'b0, 32'h8000_0084, 32'h0, 8'h00, t);
        sb.push_back('{1'b1, 32'h0BAD_F00D, 1'b0, t + 3});
        wait_resp(tr);
        e = sb.pop_front();
        checks++;
        if (tr != e.t || {a_lsu_done, a_err, a_lsu_rdata} !== {1'b1, e.err, e.data}) begin
            errors++;
            $display("FAIL mid_reset_fresh got t=%0d done=%b err=%b data=%h want t=%0d 1 0 %h",
                     tr, a_lsu_done, a_err, a_lsu_rdata, e.t, e.data);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_arb();
        test_ifu_read();
        test_lsu_write();
        test_lsu_read();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
